// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: sequences trap entry (mepc/mcause save, vector jump) and mret return.
// Optional vectored interrupt dispatch is enabled by defining TRAP_VECTORED_EN.
module trap_ctrl #(
  parameter int unsigned IRQ_SYNC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrValid,
  input  logic [31:0] pc,
  input  logic        misalignedFetch,
  input  logic        illegalInstr,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        misalignedStore,
  input  logic        misalignedLoad,
  input  logic        mret,
  input  logic        extIrq,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        mepcWe,
  output logic [31:0] mepcWd,
  output logic        mcauseWe,
  output logic [31:0] mcauseWd,
  output logic        flush,
  output logic        pcRedirect,
  output logic [31:0] pcTarget,
  output logic        busy
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] IRQ_CAUSE = 32'h8000_000B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    JUMP = 2'd2,
    RET  = 2'd3
  } stateT;

  stateT                state;
  stateT                stateNext;
  logic                 irqMask;
  logic                 irqMaskNext;
  logic [IRQ_SYNC-1:0]  irqSync;
  logic                 irqPending;
  logic                 excAny;
  logic [XLEN-1:0]      excCause;
  logic [XLEN-1:0]      trapTarget;

  logic                 mepcWeNext;
  logic                 mcauseWeNext;
  logic                 flushNext;
  logic                 pcRedirectNext;
  logic                 busyNext;
  logic [XLEN-1:0]      mepcWdNext;
  logic [XLEN-1:0]      mcauseWdNext;
  logic [XLEN-1:0]      pcTargetNext;

  // extIrq is asynchronous to clk; bring it through a flop chain before use
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irqSync <= '0;
    else       irqSync <= {irqSync[IRQ_SYNC-2:0], extIrq};
  end

  assign irqPending = irqSync[IRQ_SYNC-1] && !irqMask;
  assign excAny     = misalignedFetch | illegalInstr | ecall | ebreak
                    | misalignedStore | misalignedLoad;

  // Fixed exception priority; only meaningful when excAny is set
  always_comb begin
    excCause = XLEN'(4);
    if      (misalignedFetch) excCause = XLEN'(0);
    else if (illegalInstr)    excCause = XLEN'(2);
    else if (ecall)           excCause = XLEN'(11);
    else if (ebreak)          excCause = XLEN'(3);
    else if (misalignedStore) excCause = XLEN'(6);
  end

`ifdef TRAP_VECTORED_EN
  always_comb begin
    trapTarget = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && mcauseWd[31])
      trapTarget = {mtvec[31:2], 2'b00} + {mcauseWd[29:0], 2'b00};
  end
`else
  logic unusedMtvecMode;
  assign unusedMtvecMode = ^mtvec[1:0];
  assign trapTarget      = {mtvec[31:2], 2'b00};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      irqMask <= 1'b0;
    end else begin
      state   <= stateNext;
      irqMask <= irqMaskNext;
    end
  end

  // Next state plus next value of every registered output
  always_comb begin
    stateNext      = state;
    irqMaskNext    = irqMask;
    mepcWeNext     = 1'b0;
    mcauseWeNext   = 1'b0;
    flushNext      = 1'b0;
    pcRedirectNext = 1'b0;
    mepcWdNext     = mepcWd;
    mcauseWdNext   = mcauseWd;
    pcTargetNext   = pcTarget;
    case (state)
      IDLE: begin
        if (instrValid && (irqPending || excAny)) begin
          stateNext    = SAVE;
          mepcWeNext   = 1'b1;
          mcauseWeNext = 1'b1;
          flushNext    = 1'b1;
          mepcWdNext   = pc;
          mcauseWdNext = irqPending ? IRQ_CAUSE : excCause;
        end else if (instrValid && mret) begin
          stateNext      = RET;
          pcRedirectNext = 1'b1;
          pcTargetNext   = mepc;
          flushNext      = 1'b1;
        end
      end
      SAVE: begin
        stateNext      = JUMP;
        irqMaskNext    = 1'b1;
        pcRedirectNext = 1'b1;
        pcTargetNext   = trapTarget;
      end
      JUMP: stateNext = IDLE;
      RET: begin
        stateNext   = IDLE;
        irqMaskNext = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mepcWe     <= 1'b0;
      mcauseWe   <= 1'b0;
      flush      <= 1'b0;
      pcRedirect <= 1'b0;
      busy       <= 1'b0;
      mepcWd     <= '0;
      mcauseWd   <= '0;
      pcTarget   <= '0;
    end else begin
      mepcWe     <= mepcWeNext;
      mcauseWe   <= mcauseWeNext;
      flush      <= flushNext;
      pcRedirect <= pcRedirectNext;
      busy       <= busyNext;
      mepcWd     <= mepcWdNext;
      mcauseWd   <= mcauseWdNext;
      pcTarget   <= pcTargetNext;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized and directed bench for trap_ctrl, checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_trap_ctrl;

  localparam int unsigned IRQ_SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        instrValid;
  logic [31:0] pc;
  logic        misalignedFetch, illegalInstr, ecall, ebreak, misalignedStore, misalignedLoad;
  logic        mret;
  logic        extIrq;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mepcWe, mcauseWe, flush, pcRedirect, busy;
  logic [31:0] mepcWd, mcauseWd, pcTarget;

  trap_ctrl #(.IRQ_SYNC(IRQ_SYNC)) dut (
    .clk(clk), .reset(reset), .instrValid(instrValid), .pc(pc),
    .misalignedFetch(misalignedFetch), .illegalInstr(illegalInstr), .ecall(ecall),
    .ebreak(ebreak), .misalignedStore(misalignedStore), .misalignedLoad(misalignedLoad),
    .mret(mret), .extIrq(extIrq), .mtvec(mtvec), .mepc(mepc),
    .mepcWe(mepcWe), .mepcWd(mepcWd), .mcauseWe(mcauseWe), .mcauseWd(mcauseWd),
    .flush(flush), .pcRedirect(pcRedirect), .pcTarget(pcTarget), .busy(busy)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nBad    = 0;
  int dutWrites = 0;

  // Reference model: expected registered outputs plus trap bookkeeping
  bit          irqHist[$];
  bit          mMask;
  int          mLeft;
  bit          mIsRet;
  logic        mWe, mFlush, mRedir, mBusy;
  logic [31:0] mEpc, mCause, mTarget;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] excCode();
    if (misalignedFetch) return 32'd0;
    if (illegalInstr)    return 32'd2;
    if (ecall)           return 32'd11;
    if (ebreak)          return 32'd3;
    if (misalignedStore) return 32'd6;
    return 32'd4;
  endfunction

  function automatic logic [31:0] jumpTarget(input logic [31:0] tv, input logic [31:0] cause);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
    if (tv[1:0] == 2'b01 && cause[31]) return base + 32'(cause[30:0]) * 32'd4;
`endif
    return base;
  endfunction

  task automatic modelReset();
    irqHist.delete();
    for (int i = 0; i < int'(IRQ_SYNC); i++) irqHist.push_back(1'b0);
    mMask = 0; mLeft = 0; mIsRet = 0;
    mWe = 0; mFlush = 0; mRedir = 0; mBusy = 0;
    mEpc = '0; mCause = '0; mTarget = '0;
  endtask

  // One clock edge of the model, using the inputs as seen at that edge
  task automatic modelEdge();
    bit irqSeen, pend, exc;
    if (reset) begin
      modelReset();
      return;
    end
    irqSeen = irqHist.pop_front();
    irqHist.push_back(extIrq);
    pend = irqSeen && !mMask;
    exc  = misalignedFetch | illegalInstr | ecall | ebreak | misalignedStore | misalignedLoad;
    if (mLeft == 0) begin
      mWe = 0; mFlush = 0; mRedir = 0; mBusy = 0;
      if (instrValid && (pend || exc)) begin
        mWe = 1; mFlush = 1; mBusy = 1;
        mEpc = pc;
        mCause = pend ? 32'h8000_000B : excCode();
        mLeft = 2; mIsRet = 0;
      end else if (instrValid && mret) begin
        mRedir = 1; mFlush = 1; mBusy = 1;
        mTarget = mepc;
        mLeft = 1; mIsRet = 1;
      end
    end else if (mLeft == 2) begin
      mMask = 1;
      mWe = 0; mFlush = 0; mRedir = 1;
      mTarget = jumpTarget(mtvec, mCause);
      mLeft = 1;
    end else begin
      if (mIsRet) mMask = 0;
      mWe = 0; mFlush = 0; mRedir = 0; mBusy = 0;
      mLeft = 0;
    end
  endtask

  task automatic compareAll();
    checkVal("mepcWe", mepcWe, mWe);
    checkVal("mcauseWe", mcauseWe, mWe);
    checkVal("flush", flush, mFlush);
    checkVal("pcRedirect", pcRedirect, mRedir);
    checkVal("busy", busy, mBusy);
    checkVal("mepcWd", mepcWd, mEpc);
    checkVal("mcauseWd", mcauseWd, mCause);
    checkVal("pcTarget", pcTarget, mTarget);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
    if (mepcWe) dutWrites++;
    @(negedge clk);
  endtask

  task automatic clearFlags();
    instrValid = 0; misalignedFetch = 0; illegalInstr = 0; ecall = 0;
    ebreak = 0; misalignedStore = 0; misalignedLoad = 0; mret = 0;
  endtask

  initial begin
    bit found;
    int w0;
    logic [31:0] tmp;
    logic [31:0] expTgt;

    reset = 1; clearFlags(); extIrq = 0; pc = '0; mtvec = '0; mepc = '0;
    modelReset();
    stepCycle();
    stepCycle();
    checkVal("reset_busy", busy, 0);
    checkVal("reset_pcTarget", pcTarget, 0);
    reset = 0;
    stepCycle();

    // Held interrupt: taken after synchronization, then masked
    extIrq = 1; mtvec = 32'h201; pc = 32'h80; instrValid = 1;
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      stepCycle();
      if (mcauseWe) found = 1;
    end
    checkVal("irq_taken", 32'(found), 1);
    checkVal("irq_cause", mcauseWd, 32'h8000_000B);
    checkVal("irq_epc", mepcWd, 32'h80);
    stepCycle();
`ifdef TRAP_VECTORED_EN
    expTgt = 32'h22C;
`else
    expTgt = 32'h200;
`endif
    checkVal("irq_redirect", pcRedirect, 1);
    checkVal("irq_target", pcTarget, expTgt);
    w0 = dutWrites;
    for (int k = 0; k < 6; k++) stepCycle();
    checkVal("irq_not_retaken", 32'(dutWrites - w0), 0);

    // mret returns to mepc, then the still-high interrupt is retaken
    mret = 1; mepc = 32'h104;
    stepCycle();
    checkVal("ret_redirect", pcRedirect, 1);
    checkVal("ret_target", pcTarget, 32'h104);
    checkVal("ret_flush", flush, 1);
    mret = 0;
    found = 0;
    for (int k = 0; k < 4 && !found; k++) begin
      stepCycle();
      if (mcauseWe) found = 1;
    end
    checkVal("irq_retaken", 32'(found), 1);
    checkVal("irq_retaken_cause", mcauseWd, 32'h8000_000B);
    extIrq = 0; clearFlags();
    for (int k = 0; k < int'(IRQ_SYNC) + 3; k++) stepCycle();

    // Illegal instruction
    instrValid = 1; illegalInstr = 1; pc = 32'h100; mtvec = 32'h200;
    stepCycle();
    clearFlags();
    checkVal("ill_epc", mepcWd, 32'h100);
    checkVal("ill_cause", mcauseWd, 32'd2);
    checkVal("ill_we", mepcWe, 1);
    checkVal("ill_flush", flush, 1);
    stepCycle();
    checkVal("ill_redirect", pcRedirect, 1);
    checkVal("ill_target", pcTarget, 32'h200);
    stepCycle();

    // ecall + misalignedLoad + mret: exception wins, flags held through the trap are ignored
    instrValid = 1; ecall = 1; misalignedLoad = 1; mret = 1; pc = 32'h40; mepc = 32'h999;
    w0 = dutWrites;
    stepCycle();
    checkVal("prio_cause", mcauseWd, 32'd11);
    checkVal("prio_epc", mepcWd, 32'h40);
    stepCycle();
    checkVal("prio_no_ret_target", pcTarget, 32'h200);
    checkVal("prio_no_rewrite", mepcWe, 0);
    stepCycle();
    clearFlags();
    checkVal("single_write", 32'(dutWrites - w0), 1);
    checkVal("no_second_redirect", pcRedirect, 0);
    stepCycle();

    // Asynchronous reset while in SAVE
    instrValid = 1; ebreak = 1; pc = 32'h300;
    stepCycle();
    clearFlags();
    reset = 1;
    #1;
    checkVal("arst_mepcWe", mepcWe, 0);
    checkVal("arst_mcauseWe", mcauseWe, 0);
    checkVal("arst_flush", flush, 0);
    checkVal("arst_redirect", pcRedirect, 0);
    checkVal("arst_busy", busy, 0);
    modelReset();
    stepCycle();
    reset = 0;
    stepCycle();
    checkVal("arst_no_redirect", pcRedirect, 0);
    stepCycle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      instrValid      = ($urandom_range(3) != 0);
      pc              = $urandom;
      misalignedFetch = ($urandom_range(31) == 0);
      illegalInstr    = ($urandom_range(23) == 0);
      ecall           = ($urandom_range(23) == 0);
      ebreak          = ($urandom_range(23) == 0);
      misalignedStore = ($urandom_range(23) == 0);
      misalignedLoad  = ($urandom_range(23) == 0);
      mret            = ($urandom_range(5) == 0);
      if ($urandom_range(11) == 0) extIrq = ~extIrq;
      tmp   = $urandom;
      mtvec = {tmp[31:2], 2'($urandom_range(1))};
      mepc  = $urandom;
      reset = ($urandom_range(199) == 0);
      stepCycle();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
